// File: rtl/fx2_pkg.sv
// Shared types and constants for the FX2 slave-FIFO bus scheduler.
package fx2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_SETUP,
      ST_RD_BURST,
      ST_WR_SETUP,
      ST_WR_BURST,
      ST_PKTEND,
      ST_TURN
   } fx2_state_t;

   localparam logic [1:0] FADDR_EP2  = 2'b00;
   localparam logic [1:0] FADDR_EP6  = 2'b10;

   localparam logic [1:0] GRANT_NONE = 2'b00;
   localparam logic [1:0] GRANT_RD   = 2'b01;
   localparam logic [1:0] GRANT_WR   = 2'b10;

   // Bus owner as seen from outside: turnaround and idle report no owner.
   function automatic logic [1:0] grantFor(input fx2_state_t s);
      logic [1:0] g;
      g = GRANT_NONE;
      case (s)
         ST_RD_SETUP, ST_RD_BURST:           g = GRANT_RD;
         ST_WR_SETUP, ST_WR_BURST, ST_PKTEND: g = GRANT_WR;
         default:                            g = GRANT_NONE;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/fx2_rr_arb.sv
// Two-requester round-robin arbiter; remembers which direction owned the bus last.
module fx2_rr_arb (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_rdReq,
   input  logic i_wrReq,
   input  logic i_endRd,
   input  logic i_endWr,
   output logic o_pickRd,
   output logic o_pickWr
);
   import fx2_pkg::*;

   logic [1:0] r_lastGrant;
   logic       w_lastWasWr;

   // Record the direction of each burst as it ends; starts as WR so a read wins the first tie.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_lastGrant <= GRANT_WR;
      end else if (i_endRd) begin
         r_lastGrant <= GRANT_RD;
      end else if (i_endWr) begin
         r_lastGrant <= GRANT_WR;
      end
   end

   assign w_lastWasWr = (r_lastGrant == GRANT_WR);
   assign o_pickRd    = i_rdReq & (~i_wrReq | w_lastWasWr);
   assign o_pickWr    = i_wrReq & (~i_rdReq | ~w_lastWasWr);

endmodule

// File: rtl/fx2_fifo_scheduler.sv
// Shares the FX2 16-bit FIFO bus between the EP2 read stream and the EP6 write stream.
module fx2_fifo_scheduler #(
   parameter int BURST_LEN = 256,
   parameter int PKT_WORDS = 256
) (
   input  logic        fx2_ifclk,
   input  logic        rst,
   input  logic        fx2_flagb,
   input  logic        fx2_flagc,
   input  logic [15:0] fx2_fdata_in,
   output logic [15:0] fx2_fdata_out,
   output logic        fx2_fdata_oe,
   output logic [1:0]  fx2_faddr,
   output logic        fx2_slrd,
   output logic        fx2_slwr,
   output logic        fx2_sloe,
   output logic        fx2_pkt_end,
   output logic        fx2_slcs,
   output logic [15:0] rx_data,
   output logic        rx_valid,
   input  logic        rx_ready,
   input  logic [15:0] tx_data,
   input  logic        tx_valid,
   output logic        tx_ready,
   input  logic        tx_flush,
   output logic [1:0]  grant
);
   import fx2_pkg::*;

   localparam int BCW = $clog2(BURST_LEN) + 1;
   localparam int PCW = $clog2(PKT_WORDS);
   localparam logic [BCW-1:0] BURST_MAX = BCW'(BURST_LEN);
   localparam logic [BCW-1:0] BURST_ONE = BCW'(1);
   localparam logic [PCW-1:0] PART_LAST = PCW'(PKT_WORDS - 1);
   localparam logic [PCW-1:0] PART_ONE  = PCW'(1);

   fx2_state_t     r_state;
   logic [BCW-1:0] r_burstCnt;
   logic [PCW-1:0] r_partCnt;
   logic [15:0]    r_rxData;
   logic           r_rxValid;
   logic           r_slcs;

   logic w_rdReq, w_wrReq, w_partNz, w_burstRoom;
   logic w_doRead, w_doWrite, w_endRd, w_endWr;
   logic w_pickRd, w_pickWr;

   assign w_rdReq     = fx2_flagb & rx_ready;
   assign w_partNz    = (r_partCnt != '0);
   assign w_wrReq     = (tx_valid & fx2_flagc) | (tx_flush & w_partNz);
   assign w_burstRoom = (r_burstCnt < BURST_MAX);
   assign w_doRead    = (r_state == ST_RD_BURST) & w_rdReq & w_burstRoom;
   assign w_doWrite   = (r_state == ST_WR_BURST) & tx_valid & fx2_flagc & w_burstRoom;
   assign w_endRd     = (r_state == ST_RD_BURST) & ~w_doRead;
   assign w_endWr     = (r_state == ST_WR_BURST) & ~w_doWrite;

   fx2_rr_arb u_arb (
      .i_clk    (fx2_ifclk),
      .i_rst    (rst),
      .i_rdReq  (w_rdReq),
      .i_wrReq  (w_wrReq),
      .i_endRd  (w_endRd),
      .i_endWr  (w_endWr),
      .o_pickRd (w_pickRd),
      .o_pickWr (w_pickWr)
   );

   // Bus sequencer: grant, setup, burst, optional short-packet commit, then turnaround.
   always_ff @(posedge fx2_ifclk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_burstCnt <= '0;
         r_partCnt  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_pickRd) begin
                  r_state    <= ST_RD_SETUP;
                  r_burstCnt <= '0;
               end else if (w_pickWr) begin
                  r_state    <= ST_WR_SETUP;
                  r_burstCnt <= '0;
               end
            end
            ST_RD_SETUP: r_state <= ST_RD_BURST;
            ST_RD_BURST: begin
               if (w_doRead) begin
                  r_burstCnt <= r_burstCnt + BURST_ONE;
               end else begin
                  r_state <= ST_TURN;
               end
            end
            ST_WR_SETUP: r_state <= ST_WR_BURST;
            ST_WR_BURST: begin
               if (w_doWrite) begin
                  r_burstCnt <= r_burstCnt + BURST_ONE;
                  r_partCnt  <= (r_partCnt == PART_LAST) ? '0 : r_partCnt + PART_ONE;
               end else if (tx_flush & w_partNz & fx2_flagc) begin
                  r_state <= ST_PKTEND;
               end else begin
                  r_state <= ST_TURN;
               end
            end
            ST_PKTEND: begin
               r_partCnt <= '0;
               r_state   <= ST_TURN;
            end
            ST_TURN:  r_state <= ST_IDLE;
            default:  r_state <= ST_IDLE;
         endcase
      end
   end

   // Capture each strobed pad word for the read stream and hold chip select low once out of reset.
   always_ff @(posedge fx2_ifclk) begin
      if (rst) begin
         r_rxData  <= '0;
         r_rxValid <= 1'b0;
         r_slcs    <= 1'b1;
      end else begin
         r_slcs    <= 1'b0;
         r_rxValid <= w_doRead;
         if (w_doRead) begin
            r_rxData <= fx2_fdata_in;
         end
      end
   end

   // Pin controls decoded purely from the registered state so they never glitch with live flags.
   always_comb begin
      fx2_faddr    = FADDR_EP2;
      fx2_sloe     = 1'b1;
      fx2_fdata_oe = 1'b0;
      fx2_pkt_end  = 1'b1;
      case (r_state)
         ST_RD_SETUP, ST_RD_BURST: begin
            fx2_sloe = 1'b0;
         end
         ST_WR_SETUP, ST_WR_BURST: begin
            fx2_faddr    = FADDR_EP6;
            fx2_fdata_oe = 1'b1;
         end
         ST_PKTEND: begin
            fx2_faddr    = FADDR_EP6;
            fx2_fdata_oe = 1'b1;
            fx2_pkt_end  = 1'b0;
         end
         default: begin
            fx2_faddr = FADDR_EP2;
         end
      endcase
   end

   assign grant         = grantFor(r_state);
   assign fx2_slrd      = ~w_doRead;
   assign fx2_slwr      = ~w_doWrite;
   assign tx_ready      = w_doWrite;
   assign fx2_fdata_out = (r_state == ST_WR_BURST) ? tx_data : 16'h0000;
   assign fx2_slcs      = r_slcs;
   assign rx_data       = r_rxData;
   assign rx_valid      = r_rxValid;

endmodule

// File: tb/tb_fx2_fifo_scheduler.sv
// Randomized and directed bench for fx2_fifo_scheduler against a transaction-level bus model.
module tb_fx2_fifo_scheduler;

   localparam int BURST = 256;
   localparam int PKT   = 256;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flagb = 1'b0, flagc = 1'b0;
   logic [15:0] fdataIn = 16'h0;
   logic [15:0] fdataOut;
   logic        fdataOe;
   logic [1:0]  faddr;
   logic        slrd, slwr, sloe, pktEnd, slcs;
   logic [15:0] rxData;
   logic        rxValid;
   logic        rxReady = 1'b0;
   logic [15:0] txData = 16'h0;
   logic        txValid = 1'b0;
   logic        txReady;
   logic        txFlush = 1'b0;
   logic [1:0]  grant;

   int assertCount = 0;
   int failCount   = 0;
   bit checkEn     = 1'b0;

   fx2_fifo_scheduler #(.BURST_LEN(BURST), .PKT_WORDS(PKT)) dut (
      .fx2_ifclk     (clk),
      .rst           (rst),
      .fx2_flagb     (flagb),
      .fx2_flagc     (flagc),
      .fx2_fdata_in  (fdataIn),
      .fx2_fdata_out (fdataOut),
      .fx2_fdata_oe  (fdataOe),
      .fx2_faddr     (faddr),
      .fx2_slrd      (slrd),
      .fx2_slwr      (slwr),
      .fx2_sloe      (sloe),
      .fx2_pkt_end   (pktEnd),
      .fx2_slcs      (slcs),
      .rx_data       (rxData),
      .rx_valid      (rxValid),
      .rx_ready      (rxReady),
      .tx_data       (txData),
      .tx_valid      (txValid),
      .tx_ready      (txReady),
      .tx_flush      (txFlush),
      .grant         (grant)
   );

   // Free-running interface clock.
   always #5 clk = ~clk;

   // Model of the bus: which phase of an ownership period we are in, who owns it, and counters.
   // Phases: 0 idle, 1 setup, 2 burst, 3 commit, 4 turnaround.
   int          mPhase  = 0;
   bit          mWrDir  = 1'b0;
   int          mBurst  = 0;
   int          mPart   = 0;
   bit          mLastWr = 1'b1;
   logic [15:0] mRxData = 16'h0;
   bit          mRxValid = 1'b0;
   bit          mSlcs   = 1'b1;

   function automatic bit modelRead();
      return (mPhase == 2) && !mWrDir && (flagb === 1'b1) && (rxReady === 1'b1) && (mBurst < BURST);
   endfunction

   function automatic bit modelWrite();
      return (mPhase == 2) && mWrDir && (txValid === 1'b1) && (flagc === 1'b1) && (mBurst < BURST);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic reportTimeout(input string name);
      assertCount++;
      failCount++;
      $display("[TB] FAIL %s: timed out waiting for DUT at %0t", name, $time);
   endtask

   task automatic applyStimulus(input logic b, input logic rr, input logic c, input logic tv, input logic tf);
      flagb   = b;
      rxReady = rr;
      flagc   = c;
      txValid = tv;
      txFlush = tf;
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
      fdataIn = 16'($urandom);
      txData  = 16'($urandom);
   endtask

   task automatic quiesce();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (6) stepCycle();
   endtask

   // Advance the model on every clock edge from the inputs present at that edge.
   always @(posedge clk) begin : modelUpdate
      int nPhase, nBurst, nPart;
      bit nWrDir, nLastWr, rdNow, wrNow, rdReq, wrReq;
      if (rst === 1'b1) begin
         mPhase   <= 0;
         mWrDir   <= 1'b0;
         mBurst   <= 0;
         mPart    <= 0;
         mLastWr  <= 1'b1;
         mRxData  <= 16'h0;
         mRxValid <= 1'b0;
         mSlcs    <= 1'b1;
      end else begin
         rdNow   = modelRead();
         wrNow   = modelWrite();
         nPhase  = mPhase;
         nBurst  = mBurst;
         nPart   = mPart;
         nWrDir  = mWrDir;
         nLastWr = mLastWr;
         case (mPhase)
            0: begin
               rdReq = (flagb === 1'b1) && (rxReady === 1'b1);
               wrReq = ((txValid === 1'b1) && (flagc === 1'b1)) || ((txFlush === 1'b1) && mPart != 0);
               if (rdReq || wrReq) begin
                  nWrDir = (rdReq && wrReq) ? !mLastWr : wrReq;
                  nPhase = 1;
                  nBurst = 0;
               end
            end
            1: nPhase = 2;
            2: begin
               if (!mWrDir) begin
                  if (rdNow) nBurst = mBurst + 1;
                  else begin
                     nPhase  = 4;
                     nLastWr = 1'b0;
                  end
               end else begin
                  if (wrNow) begin
                     nBurst = mBurst + 1;
                     nPart  = (mPart + 1) % PKT;
                  end else begin
                     nLastWr = 1'b1;
                     nPhase  = ((txFlush === 1'b1) && mPart != 0 && (flagc === 1'b1)) ? 3 : 4;
                  end
               end
            end
            3: begin
               nPart  = 0;
               nPhase = 4;
            end
            default: nPhase = 0;
         endcase
         mPhase   <= nPhase;
         mBurst   <= nBurst;
         mPart    <= nPart;
         mWrDir   <= nWrDir;
         mLastWr  <= nLastWr;
         mSlcs    <= 1'b0;
         mRxValid <= rdNow;
         if (rdNow) mRxData <= fdataIn;
      end
   end

   // Compare every DUT output against the model half a cycle after each edge.
   always @(negedge clk) begin : compare
      bit owns, rdNow, wrNow;
      if (checkEn) begin
         owns  = (mPhase >= 1) && (mPhase <= 3);
         rdNow = modelRead();
         wrNow = modelWrite();
         checkOutput("slrd",     32'(slrd),     32'(!rdNow));
         checkOutput("slwr",     32'(slwr),     32'(!wrNow));
         checkOutput("txReady",  32'(txReady),  32'(wrNow));
         checkOutput("sloe",     32'(sloe),     32'(!(owns && !mWrDir)));
         checkOutput("oe",       32'(fdataOe),  32'(owns && mWrDir));
         checkOutput("faddr",    32'(faddr),    (owns && mWrDir) ? 32'd2 : 32'd0);
         checkOutput("pktEnd",   32'(pktEnd),   32'(mPhase != 3));
         checkOutput("grant",    32'(grant),    owns ? (mWrDir ? 32'd2 : 32'd1) : 32'd0);
         checkOutput("fdataOut", 32'(fdataOut), (mPhase == 2 && mWrDir) ? 32'(txData) : 32'd0);
         checkOutput("rxData",   32'(rxData),   32'(mRxData));
         checkOutput("rxValid",  32'(rxValid),  32'(mRxValid));
         checkOutput("slcs",     32'(slcs),     32'(mSlcs));
         checkOutput("oeSloeOverlap", 32'(fdataOe & ~sloe), 32'd0);
      end
   end

   initial begin
      int n, guard, runs, runLen, badAddr, pe, cnt, idleRun, lastDir, nGrants;
      bit prevLow, haveDir, pendPad, padDone;
      logic [15:0] padSave;
      logic [1:0]  prevGrant, lastNz;

      // Reset state with hand-computed values.
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      checkEn = 1'b1;
      @(negedge clk);
      checkOutput("rstSlrd",   32'(slrd),     32'd1);
      checkOutput("rstSlwr",   32'(slwr),     32'd1);
      checkOutput("rstSloe",   32'(sloe),     32'd1);
      checkOutput("rstPktEnd", 32'(pktEnd),   32'd1);
      checkOutput("rstSlcs",   32'(slcs),     32'd1);
      checkOutput("rstFaddr",  32'(faddr),    32'd0);
      checkOutput("rstOe",     32'(fdataOe),  32'd0);
      checkOutput("rstFdata",  32'(fdataOut), 32'd0);
      checkOutput("rstRx",     32'({rxValid, rxData}), 32'd0);
      checkOutput("rstTxRdy",  32'(txReady),  32'd0);
      checkOutput("rstGrant",  32'(grant),    32'd0);
      stepCycle();
      rst = 1'b0;
      quiesce();

      // Reads only: first burst is exactly BURST strobes at EP2, then a second burst begins.
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      runs = 0; runLen = 0; badAddr = 0; prevLow = 1'b0; pendPad = 1'b0; padDone = 1'b0; padSave = '0;
      for (int i = 0; i < 300; i++) begin
         stepCycle();
         @(negedge clk);
         if (pendPad) begin
            checkOutput("rxLatencyData",  32'(rxData),  32'(padSave));
            checkOutput("rxLatencyValid", 32'(rxValid), 32'd1);
            pendPad = 1'b0;
            padDone = 1'b1;
         end
         if (slrd == 1'b0) begin
            if (!prevLow) runs++;
            if (runs == 1) runLen++;
            if (faddr != 2'b00) badAddr++;
            if (!padDone && !pendPad) begin
               padSave = fdataIn;
               pendPad = 1'b1;
            end
         end
         prevLow = (slrd == 1'b0);
      end
      checkOutput("firstRdBurstLen", 32'(runLen),  32'd256);
      checkOutput("rdBurstsSeen",    32'(runs),    32'd2);
      checkOutput("rdFaddrBad",      32'(badAddr), 32'd0);
      quiesce();

      // Short packet: five words then flush gives one commit at EP6.
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      n = 0; guard = 0;
      while (n < 5 && guard < 50) begin
         @(negedge clk);
         if (txReady === 1'b1 && slwr === 1'b0) n++;
         stepCycle();
         guard++;
         if (n == 5) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      end
      if (n < 5) reportTimeout("shortPktWrites");
      checkOutput("shortWrCount", 32'(n), 32'd5);
      pe = 0; badAddr = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (pktEnd == 1'b0) begin
            pe++;
            if (faddr != 2'b10) badAddr++;
         end
         stepCycle();
      end
      checkOutput("shortPktEndCount", 32'(pe),      32'd1);
      checkOutput("pktEndFaddr",      32'(badAddr), 32'd0);

      // A second flush with nothing pending is ignored entirely.
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      stepCycle();
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      pe = 0; cnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (pktEnd == 1'b0) pe++;
         if (grant != 2'b00) cnt++;
         stepCycle();
      end
      checkOutput("secondFlushPktEnd", 32'(pe),  32'd0);
      checkOutput("secondFlushGrant",  32'(cnt), 32'd0);
      quiesce();

      // Full packet then flush: counter wrapped, so no commit.
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      n = 0; guard = 0;
      while (n < 256 && guard < 400) begin
         @(negedge clk);
         if (txReady === 1'b1 && slwr === 1'b0) n++;
         stepCycle();
         guard++;
         if (n == 256) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      end
      if (n < 256) reportTimeout("fullPktWrites");
      checkOutput("fullWrCount", 32'(n), 32'd256);
      pe = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (pktEnd == 1'b0) pe++;
         stepCycle();
      end
      checkOutput("fullPktFlushPktEnd", 32'(pe), 32'd0);
      quiesce();

      // Flow control: EP6 full after ten words stops the strobe in the same cycle.
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      n = 0; guard = 0;
      while (n < 10 && guard < 50) begin
         @(negedge clk);
         if (txReady === 1'b1 && slwr === 1'b0) n++;
         stepCycle();
         guard++;
         if (n == 10) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      end
      if (n < 10) reportTimeout("flowWrites");
      @(negedge clk);
      checkOutput("slwrStopSameCycle", 32'(slwr), 32'd1);
      for (int i = 0; i < 10; i++) begin
         if (txReady === 1'b1) n++;
         stepCycle();
         @(negedge clk);
      end
      checkOutput("flowWrCount", 32'(n), 32'd10);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      repeat (8) stepCycle();
      quiesce();

      // EP2 going empty mid-burst stops the read strobe in the same cycle.
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      n = 0; guard = 0;
      while (n < 20 && guard < 60) begin
         @(negedge clk);
         if (slrd === 1'b0) n++;
         stepCycle();
         guard++;
         if (n == 20) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      end
      if (n < 20) reportTimeout("rdStopReads");
      @(negedge clk);
      checkOutput("slrdStopSameCycle", 32'(slrd), 32'd1);
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         stepCycle();
         @(negedge clk);
         if (slrd == 1'b0) cnt++;
      end
      checkOutput("rdStopExtraReads", 32'(cnt), 32'd0);
      quiesce();

      // Contention: grants alternate and each direction change has a dead gap of at least three cycles.
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      idleRun = 0; haveDir = 1'b0; lastDir = 0; nGrants = 0; prevGrant = 2'b00; lastNz = 2'b00;
      for (int i = 0; i < 1100; i++) begin
         stepCycle();
         @(negedge clk);
         if (grant != 2'b00 && prevGrant == 2'b00) begin
            if (nGrants > 0) checkOutput("grantAlternates", 32'(grant), 32'(lastNz ^ 2'b11));
            lastNz = grant;
            nGrants++;
         end
         prevGrant = grant;
         if (slrd == 1'b0 || slwr == 1'b0) begin
            if (haveDir && lastDir != int'(slwr == 1'b0)) checkOutput("switchGapAtLeast3", 32'(idleRun >= 3), 32'd1);
            lastDir = int'(slwr == 1'b0);
            haveDir = 1'b1;
            idleRun = 0;
         end else begin
            idleRun++;
         end
      end
      checkOutput("contentionGrantsSeen", 32'(nGrants >= 3), 32'd1);
      quiesce();

      // Reset during a write burst drops every strobe and the bus on the next edge.
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      guard = 0;
      @(negedge clk);
      while (txReady !== 1'b1 && guard < 20) begin
         stepCycle();
         @(negedge clk);
         guard++;
      end
      if (txReady !== 1'b1) reportTimeout("reachWrBurst");
      stepCycle();
      rst = 1'b1;
      stepCycle();
      @(negedge clk);
      checkOutput("midRstOe",      32'(fdataOe), 32'd0);
      checkOutput("midRstStrobes", 32'({slrd, slwr, pktEnd, sloe}), 32'hF);
      checkOutput("midRstTxReady", 32'(txReady), 32'd0);
      checkOutput("midRstGrant",   32'(grant),   32'd0);
      stepCycle();
      rst = 1'b0;
      quiesce();

      // Randomized segments of held input patterns, checked cycle by cycle by the model.
      for (int seg = 0; seg < 150; seg++) begin
         applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 8,
                       $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
                       $urandom_range(0, 9) < 2);
         rst = ($urandom_range(0, 59) == 0);
         repeat ($urandom_range(1, 30)) stepCycle();
         rst = 1'b0;
      end
      quiesce();

      checkEn = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
